imem_loader: RTL and testbench

Boot-time writer for the instruction memory that the processor core reads.
- Accepts a byte stream over a valid/ready handshake.
- Packs each 4 bytes, little-endian, into a 32-bit word.
- Writes words to consecutive word-aligned byte addresses starting at 0.
- Holds the core in reset (cpu_hold) until the image is fully loaded. The top level drives the core reset as reset | cpu_hold.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_if.sv | 23 ++
 rtl/loader_word_assembler.sv | 52 +++++
 rtl/imem_loader.sv | 177 +++++++++++++++++
 tb/tb_imem_loader.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory boot loader.
// Holds the FSM state encoding, the word-packing geometry and the checksum helper.
package imem_loader_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RECV  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = 2;

  // The image checksum is a plain modulo-256 byte sum.
  function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master = the loader side, slave = the stream source / memory side.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/loader_word_assembler.sv
// Packs accepted stream bytes little-endian into a 32-bit word.
// o_word already includes the byte being accepted, so the caller can latch it on the last-byte edge.
module loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_ready
);

  logic [BYTE_IDX_W-1:0] r_byte_idx;
  logic [31:0]           r_word;
  logic [31:0]           w_word;

  // Merge the incoming byte into its lane of the partially assembled word.
  always_comb begin
    w_word = r_word;
    if (i_accept) begin
      case (r_byte_idx)
        2'd0:    w_word[7:0]   = i_byte;
        2'd1:    w_word[15:8]  = i_byte;
        2'd2:    w_word[23:16] = i_byte;
        2'd3:    w_word[31:24] = i_byte;
        default: w_word        = r_word;
      endcase
    end else begin
      w_word = r_word;
    end
  end

  // Byte-lane index and word storage; clear drops any partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_idx <= {BYTE_IDX_W{1'b0}};
      r_word     <= 32'h0000_0000;
    end else if (i_clear) begin
      r_byte_idx <= {BYTE_IDX_W{1'b0}};
      r_word     <= 32'h0000_0000;
    end else if (i_accept) begin
      r_byte_idx <= r_byte_idx + 2'd1;
      r_word     <= w_word;
    end
  end

  assign o_word       = w_word;
  assign o_word_ready = i_accept && (r_byte_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: byte stream in, word writes out, core held until loaded.
// Optional image checksum byte after the last word when CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic [ADDR_WIDTH:0] i_word_count,
  imem_loader_if.master       bus,
  output logic                o_cpu_hold,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error
);

  localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};
`ifdef CHECKSUM_EN
  localparam logic [2:0] FIN_STATE = CHECK;
`else
  localparam logic [2:0] FIN_STATE = DONE;
`endif
  localparam logic FIN_IS_DONE = (FIN_STATE == DONE);

  logic [2:0]          r_state;
  logic [ADDR_WIDTH:0] r_count;
  logic [ADDR_WIDTH:0] r_word_idx;
  logic                r_in_ready;
  logic                r_mem_we;
  logic [31:0]         r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_cpu_hold;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
`ifdef CHECKSUM_EN
  logic [7:0]          r_sum;
`endif

  logic                w_accept;
  logic                w_asm_accept;
  logic                w_start_ok;
  logic [31:0]         w_word;
  logic                w_word_ready;
  logic [ADDR_WIDTH:0] w_next_idx;
  logic [31:0]         w_word_addr;

  assign w_accept     = bus.in_valid && r_in_ready;
  assign w_asm_accept = w_accept && (r_state == RECV);
  assign w_start_ok   = i_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_next_idx   = r_word_idx + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign w_word_addr  = {{(30-ADDR_WIDTH){1'b0}}, r_word_idx[ADDR_WIDTH-1:0], 2'b00};

  loader_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_start_ok),
    .i_accept     (w_asm_accept),
    .i_byte       (bus.in_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  // Load sequencer; every output is a register updated on the transition into its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= {(ADDR_WIDTH+1){1'b0}};
      r_word_idx  <= {(ADDR_WIDTH+1){1'b0}};
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0000_0000;
      r_mem_wdata <= 32'h0000_0000;
      r_cpu_hold  <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
`ifdef CHECKSUM_EN
      r_sum       <= 8'h00;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_count    <= i_word_count;
            r_word_idx <= {(ADDR_WIDTH+1){1'b0}};
            r_error    <= 1'b0;
            r_cpu_hold <= 1'b1;
`ifdef CHECKSUM_EN
            r_sum      <= 8'h00;
`endif
            if (i_word_count == {(ADDR_WIDTH+1){1'b0}}) begin
              r_state    <= FIN_STATE;
              r_in_ready <= !FIN_IS_DONE;
              r_busy     <= !FIN_IS_DONE;
              r_done     <= FIN_IS_DONE;
              r_cpu_hold <= !FIN_IS_DONE;
            end else if (i_word_count > CAPACITY) begin
              r_state <= IDLE;
              r_error <= 1'b1;
              r_done  <= 1'b0;
            end else begin
              r_state    <= RECV;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
              r_done     <= 1'b0;
            end
          end
        end
        RECV: begin
`ifdef CHECKSUM_EN
          if (w_accept) begin
            r_sum <= csum_add(r_sum, bus.in_data);
          end
`endif
          if (w_word_ready) begin
            r_state     <= WRITE;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_word_addr;
            r_mem_wdata <= w_word;
          end
        end
        WRITE: begin
          r_mem_we   <= 1'b0;
          r_word_idx <= w_next_idx;
          if (w_next_idx == r_count) begin
            r_state    <= FIN_STATE;
            r_in_ready <= !FIN_IS_DONE;
            r_busy     <= !FIN_IS_DONE;
            r_done     <= FIN_IS_DONE;
            r_cpu_hold <= !FIN_IS_DONE;
          end else begin
            r_state    <= RECV;
            r_in_ready <= 1'b1;
          end
        end
`ifdef CHECKSUM_EN
        CHECK: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            if (csum_add(r_sum, bus.in_data) == 8'h00) begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state    <= IDLE;
              r_error    <= 1'b1;
              r_cpu_hold <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
          r_mem_we   <= 1'b0;
          r_busy     <= 1'b0;
          r_cpu_hold <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign o_cpu_hold    = r_cpu_hold;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_error       = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load scenarios plus reset-mid-load and checksum sequences.
// Build with CHECKSUM_EN defined to exercise the checksum byte.
module tb_imem_loader;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   word_count;
  logic          cpu_hold, busy, done, error;

  imem_loader_if bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (start),
    .i_word_count (word_count),
    .bus          (bus),
    .o_cpu_hold   (cpu_hold),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  stream[0:255];

  typedef struct {
    logic [AW:0] wc;
    int          gap;
    int          exp_writes;
    logic [31:0] exp_first_data;
    logic [31:0] exp_last_addr;
    logic [31:0] exp_last_data;
    logic        exp_done;
    logic        exp_error;
    logic        exp_hold;
  } vec_t;

  vec_t vecs[6];

  // Write monitor: mem_we is a one-cycle strobe, so one sample per write.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    acc = 1'b0;
    bus.in_valid = 1'b0;
    repeat (gap) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int t = 0; t < 100 && !acc; t++) begin
      if (bus.in_ready === 1'b1) acc = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start(input logic [AW:0] wc);
    start      = 1'b1;
    word_count = wc;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_end();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 400 && !seen; t++) begin
      if (done === 1'b1 || error === 1'b1) seen = 1'b1;
      else tick();
    end
    if (!seen) check("end_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0] sum;
    int         nw;

    for (int i = 0; i < 256; i++) stream[i] = i[7:0];
    stream[0] = 8'h13; stream[1] = 8'h05; stream[2] = 8'h00; stream[3] = 8'h00;
    stream[4] = 8'h93; stream[5] = 8'h05; stream[6] = 8'h10; stream[7] = 8'h00;

    vecs[0] = '{7'd2,  0, 2,  32'h0000_0513, 32'h0000_0004, 32'h0010_0593, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{7'd2,  3, 2,  32'h0000_0513, 32'h0000_0004, 32'h0010_0593, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{7'd0,  0, 0,  32'h0,         32'h0,         32'h0,         1'b1, 1'b0, 1'b0};
    vecs[3] = '{7'd65, 0, 0,  32'h0,         32'h0,         32'h0,         1'b0, 1'b1, 1'b1};
    vecs[4] = '{7'd64, 0, 64, 32'h0000_0513, 32'h0000_00FC, 32'hFFFE_FDFC, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{7'd1,  1, 1,  32'h0000_0513, 32'h0000_0000, 32'h0000_0513, 1'b1, 1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; word_count = '0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00;
    tick(); tick();
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    reset = 1'b0;
    tick();

    for (int r = 0; r < 6; r++) begin
      wr_addr.delete(); wr_data.delete();
      sum = 8'h00;
      pulse_start(vecs[r].wc);
      if (!vecs[r].exp_error) begin
        for (int i = 0; i < int'(vecs[r].wc) * 4; i++) begin
          send_byte(stream[i], vecs[r].gap);
          sum = sum + stream[i];
        end
`ifdef CHECKSUM_EN
        send_byte(8'h00 - sum, 0);
`endif
      end
      wait_end();
      repeat (3) tick();
      check($sformatf("row%0d_writes", r), wr_addr.size(), vecs[r].exp_writes);
      check($sformatf("row%0d_done", r), done, vecs[r].exp_done);
      check($sformatf("row%0d_error", r), error, vecs[r].exp_error);
      check($sformatf("row%0d_cpu_hold", r), cpu_hold, vecs[r].exp_hold);
      check($sformatf("row%0d_busy", r), busy, 0);
      check($sformatf("row%0d_in_ready", r), bus.in_ready, 0);
      nw = wr_addr.size();
      if (nw > 0 && vecs[r].exp_writes > 0) begin
        check($sformatf("row%0d_first_data", r), wr_data[0], vecs[r].exp_first_data);
        check($sformatf("row%0d_last_addr", r), wr_addr[nw-1], vecs[r].exp_last_addr);
        check($sformatf("row%0d_last_data", r), wr_data[nw-1], vecs[r].exp_last_data);
      end
      for (int k = 0; k < nw && k < vecs[r].exp_writes; k++) begin
        check($sformatf("row%0d_w%0d_addr", r, k), wr_addr[k], 32'(k * 4));
        check($sformatf("row%0d_w%0d_data", r, k), wr_data[k],
              {stream[4*k+3], stream[4*k+2], stream[4*k+1], stream[4*k]});
      end
    end

    // Reset in the middle of the second word; a start pulse mid-load must be ignored.
    wr_addr.delete(); wr_data.delete();
    pulse_start(7'd2);
    for (int i = 0; i < 5; i++) send_byte(stream[i], 0);
    pulse_start(7'd0);
    check("midload_busy", busy, 1);
    check("midload_done", done, 0);
    send_byte(stream[5], 0);
    reset = 1'b1;
    tick();
    check("midrst_cpu_hold", cpu_hold, 1);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_done", done, 0);
    reset = 1'b0;
    repeat (10) tick();
    check("midrst_writes", wr_addr.size(), 1);
    if (wr_addr.size() > 0) begin
      check("midrst_w0_addr", wr_addr[0], 32'h0);
      check("midrst_w0_data", wr_data[0], 32'h0000_0513);
    end
    check("midrst_mem_we", bus.mem_we, 0);
    check("midrst_in_ready_late", bus.in_ready, 0);

`ifdef CHECKSUM_EN
    // Data bytes sum to 0xC0: 0x40 completes to zero, 0x41 does not.
    pulse_start(7'd2);
    for (int i = 0; i < 8; i++) send_byte(stream[i], 0);
    send_byte(8'h40, 0);
    wait_end();
    tick();
    check("csum_ok_done", done, 1);
    check("csum_ok_error", error, 0);
    check("csum_ok_cpu_hold", cpu_hold, 0);

    pulse_start(7'd2);
    for (int i = 0; i < 8; i++) send_byte(stream[i], 0);
    send_byte(8'h41, 0);
    wait_end();
    tick();
    check("csum_bad_error", error, 1);
    check("csum_bad_done", done, 0);
    check("csum_bad_cpu_hold", cpu_hold, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
